// File: rtl/pipeline_hazard_scheduler_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
//   sb_entry_t : one scoreboard slot describing an in-flight instruction
//   SB_BUBBLE  : empty slot (all fields zero)
//   FWD_*      : EX operand source encodings
//   fwdSelect  : forwarding decision for one EX source operand
package pipeline_hazard_scheduler_pkg;

  localparam int unsigned SB_REG_BITS = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic                   regWrite;
    logic                   memRead;
    logic [SB_REG_BITS-1:0] dest;
    logic [SB_REG_BITS-1:0] rs;
    logic [SB_REG_BITS-1:0] rt;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // MEM is the newer value so it wins over WB; a load in MEM has no data yet.
  function automatic logic [1:0] fwdSelect(input sb_entry_t memE,
                                           input sb_entry_t wbE,
                                           input logic [SB_REG_BITS-1:0] src);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (memE.valid && memE.regWrite && (memE.dest != '0) &&
        (memE.dest == src) && !memE.memRead) begin
      sel = FWD_MEM;
    end else if (wbE.valid && wbE.regWrite && (wbE.dest != '0) &&
                 (wbE.dest == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_scheduler_pipe_scoreboard.sv
// pipe_scoreboard: three-slot (EX, MEM, WB) shift register of in-flight
// instruction descriptors with bubble injection.
//   clk, reset   : clock, async active-low reset
//   idEntry      : descriptor of the instruction leaving ID
//   stall        : hold ID; EX receives a bubble
//   redirect     : squash EX and MEM; the MEM instruction still retires to WB
//   exEntry/memEntry/wbEntry : current slot contents
module pipe_scoreboard
  import pipeline_hazard_scheduler_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  sb_entry_t idEntry,
  input  logic      stall,
  input  logic      redirect,
  output sb_entry_t exEntry,
  output sb_entry_t memEntry,
  output sb_entry_t wbEntry
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exEntry  <= SB_BUBBLE;
      memEntry <= SB_BUBBLE;
      wbEntry  <= SB_BUBBLE;
    end else begin
      wbEntry  <= memEntry;
      memEntry <= redirect ? SB_BUBBLE : exEntry;
      exEntry  <= (stall || redirect) ? SB_BUBBLE : idEntry;
    end
  end

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// pipeline_hazard_scheduler: stall/flush/forwarding control for a 5-stage
// MIPS pipeline, driven from a private scoreboard of in-flight instructions.
//   clk, reset                : clock, async active-low reset
//   ID_*                      : decoded fields of the instruction in ID
//   MEM_Redirect              : taken branch/jump resolved in MEM
//   PC_Write, IF_ID_Write     : front-end enables (low during load-use stall)
//   ID_EX_Bubble              : insert NOP into ID/EX
//   Flush_IF_ID/ID_EX/EX_MEM  : pipeline register clears on redirect
//   ForwardA, ForwardB        : EX operand sources (from scoreboard only)
//   StallCount, FlushCount    : saturating debug event counters
module pipeline_hazard_scheduler
  import pipeline_hazard_scheduler_pkg::*;
#(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ID_Valid,
  input  logic [REG_BITS-1:0] ID_Rs,
  input  logic [REG_BITS-1:0] ID_Rt,
  input  logic                ID_UsesRs,
  input  logic                ID_UsesRt,
  input  logic [REG_BITS-1:0] ID_WriteRegister,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                MEM_Redirect,
  output logic                PC_Write,
  output logic                IF_ID_Write,
  output logic                ID_EX_Bubble,
  output logic                Flush_IF_ID,
  output logic                Flush_ID_EX,
  output logic                Flush_EX_MEM,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic [CNT_BITS-1:0] StallCount,
  output logic [CNT_BITS-1:0] FlushCount
);

  sb_entry_t idEntry;
  sb_entry_t exEntry;
  sb_entry_t memEntry;
  sb_entry_t wbEntry;
  logic      loadUse;
  logic      stall;

  // An invalid ID slot enters the scoreboard as a plain bubble.
  always_comb begin
    idEntry = SB_BUBBLE;
    if (ID_Valid) begin
      idEntry.valid    = 1'b1;
      idEntry.regWrite = ID_RegWrite;
      idEntry.memRead  = ID_MemRead;
      idEntry.dest     = SB_REG_BITS'(ID_WriteRegister);
      idEntry.rs       = SB_REG_BITS'(ID_Rs);
      idEntry.rt       = SB_REG_BITS'(ID_Rt);
    end
  end

  // Load in EX whose destination the ID instruction reads.
  always_comb begin
    loadUse = 1'b0;
    if (exEntry.valid && exEntry.memRead && (exEntry.dest != '0) && ID_Valid) begin
      loadUse = (ID_UsesRs && (exEntry.dest == SB_REG_BITS'(ID_Rs))) ||
                (ID_UsesRt && (exEntry.dest == SB_REG_BITS'(ID_Rt)));
    end
  end

  // Redirect squashes everything younger, so a coincident stall is moot.
  assign stall = loadUse && !MEM_Redirect;

  assign PC_Write     = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Bubble = stall;
  assign Flush_IF_ID  = MEM_Redirect;
  assign Flush_ID_EX  = MEM_Redirect;
  assign Flush_EX_MEM = MEM_Redirect;

  pipe_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .idEntry  (idEntry),
    .stall    (stall),
    .redirect (MEM_Redirect),
    .exEntry  (exEntry),
    .memEntry (memEntry),
    .wbEntry  (wbEntry)
  );

  assign ForwardA = fwdSelect(memEntry, wbEntry, exEntry.rs);
  assign ForwardB = fwdSelect(memEntry, wbEntry, exEntry.rt);

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_BITS'(1);
      end
      if (MEM_Redirect && (FlushCount != '1)) begin
        FlushCount <= FlushCount + CNT_BITS'(1);
      end
    end
  end

endmodule
